// File: rtl/inst_encoder_loader.sv
`timescale 1ns/1ps
// Packs decoded RV32I field bundles into instruction words and streams them into imem.
// One-cycle accept-to-write latency; in_ready is high for the whole RUN phase only.
module inst_encoder_loader #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  inst_count,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        op,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  err_index
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic [1:0]        state;
  logic [CNT_W-1:0]  remaining;
  logic [CNT_W-1:0]  idx;
  logic [ADDR_W-1:0] next_addr;

  logic        enc_ok;
  logic [31:0] enc_word;
  logic        i_ok, sh_ok, b_ok, j_ok, u_ok;

  assign in_ready = (state == S_RUN);
  assign busy     = (state == S_RUN) || (state == S_DRAIN);
  assign done     = (state == S_DONE);

  // Range checks: a signed value fits in N bits when all bits above N-1 equal the sign bit.
  assign i_ok  = (&imm[31:11]) | ~(|imm[31:11]);
  assign sh_ok = ~(|imm[31:5]);
  assign b_ok  = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
  assign j_ok  = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];
  assign u_ok  = ~(|imm[11:0]);

  always_comb begin
    enc_ok   = 1'b0;
    enc_word = 32'h0;
    case (op)
      OP_R: begin
        enc_ok   = 1'b1;
        enc_word = {funct7, rs2, rs1, funct3, rd, op};
      end
      OP_IMM: begin
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          enc_ok   = sh_ok;
          enc_word = {funct7, imm[4:0], rs1, funct3, rd, op};
        end else begin
          enc_ok   = i_ok;
          enc_word = {imm[11:0], rs1, funct3, rd, op};
        end
      end
      OP_JALR, OP_LD: begin
        enc_ok   = i_ok;
        enc_word = {imm[11:0], rs1, funct3, rd, op};
      end
      OP_ST: begin
        enc_ok   = i_ok;
        enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], op};
      end
      OP_BR: begin
        enc_ok   = b_ok;
        enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op};
      end
      OP_JAL: begin
        enc_ok   = j_ok;
        enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
      end
      OP_LUI, OP_AUIPC: begin
        enc_ok   = u_ok;
        enc_word = {imm[31:12], rd, op};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      remaining  <= '0;
      idx        <= '0;
      next_addr  <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      err        <= 1'b0;
      err_index  <= '0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (inst_count == '0) begin
              state <= S_DONE;
            end else begin
              state     <= S_RUN;
              remaining <= inst_count;
              idx       <= '0;
              next_addr <= {base_addr[ADDR_W-1:2], 2'b00};
              err       <= 1'b0;
              err_index <= '0;
            end
          end
        end
        S_RUN: begin
          if (in_valid) begin
            imem_we    <= 1'b1;
            imem_addr  <= next_addr;
            imem_wdata <= enc_ok ? enc_word : NOP;
            next_addr  <= next_addr + ADDR_W'(4);
            idx        <= idx + CNT_W'(1);
            remaining  <= remaining - CNT_W'(1);
            if (!enc_ok) begin
              err <= 1'b1;
              if (!err) err_index <= idx;
            end
            if (remaining == CNT_W'(1)) state <= S_DRAIN;
          end
        end
        S_DRAIN: state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
